// File: rtl/mac_stream_ctrl_if.sv
// Host-side bundle of the MAC stream controller: job request, operand
// stream and result stream. The master is the host, the slave is the
// controller.
interface mac_stream_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;

  modport master (
    output start, len, in_valid, in_data, res_ready,
    input  busy, in_ready, res_valid, res_data
  );

  modport slave (
    input  start, len, in_valid, in_data, res_ready,
    output busy, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_stream_ctrl.sv
// Operand feeder / result reader for the vedic-multiplier MAC.
// Clears the accumulator, streams LEN operand pairs into it, waits out the
// operand and accumulator register stages, then captures C and holds it on
// the result port until taken.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start, MAC operands held at zero
//   S_CLEAR | one-cycle mac_clr pulse, accumulator reset
//   S_FEED  | in_ready high, each accepted beat loads mac_a/mac_b
//   S_DRAIN | two cycles of zero operands so the last product lands in C
//   S_HOLD  | res_valid high, result held until res_ready
module mac_stream_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  mac_stream_ctrl_if.slave  bus,
  output logic [3:0]        mac_a,
  output logic [3:0]        mac_b,
  output logic              mac_clr,
  input  logic [7:0]        mac_c
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             drain_q, drain_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic             clr_q, clr_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state and next-output computation; operands default to zero so any
  // cycle without an accepted beat adds nothing to the accumulator.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    a_d         = 4'd0;
    b_d         = 4'd0;
    clr_d       = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = bus.len;
          cnt_d   = '0;
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        drain_d = 1'b0;
        state_d = (len_q != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        // in_ready is 1 throughout FEED, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          a_d   = bus.in_data[3:0];
          b_d   = bus.in_data[7:4];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d     = 1'b0;
          res_data_d  = mac_c;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      a_q         <= a_d;
      b_q         <= b_d;
      clr_q       <= clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = (state_q == S_FEED);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign mac_a         = a_q;
  assign mac_b         = b_q;
  assign mac_clr       = clr_q;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Directed bench for mac_stream_ctrl with a behavioural MAC accumulator.
module tb_mac_stream_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] mac_a;
  logic [3:0] mac_b;
  logic       mac_clr;
  logic [7:0] mac_c;

  int checks = 0;
  int errors = 0;

  mac_stream_ctrl_if #(.LEN_W(4)) bus ();

  mac_stream_ctrl #(.LEN_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_clr (mac_clr),
    .mac_c   (mac_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC core: accumulates every clock, mac_clr resets it. Not reset by rst,
  // and starts from a junk value, so a stale accumulator would show up.
  initial mac_c = 8'hA5;
  always @(posedge clk) begin
    if (mac_clr) mac_c <= 8'd0;
    else         mac_c <= mac_c + 8'(mac_a) * 8'(mac_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a job and streams n beats with `gap` idle cycles after each
  // accepted beat; returns once res_valid is seen (or the budget runs out).
  // lat counts edges from the start edge to the first cycle with res_valid.
  task automatic run_job(input int n, input logic [7:0] bt [4], input int gap,
                         output int lat, output int rdy_cyc, output int clr_cyc);
    int idx;
    int gcnt;
    logic rdy_now;
    logic hs;
    idx = 0;
    gcnt = 0;
    rdy_cyc = 0;
    clr_cyc = 0;
    bus.start = 1'b1;
    bus.len   = 4'(n);
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      rdy_now = bus.in_ready;
      if (rdy_now) rdy_cyc++;
      if (mac_clr) clr_cyc++;
      if (idx < n && gcnt == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = bt[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      hs = rdy_now && bus.in_valid;
      tick();
      lat++;
      if (hs) begin
        chk("mac_a_load", mac_a, bt[idx][3:0]);
        chk("mac_b_load", mac_b, bt[idx][7:4]);
        idx++;
        gcnt = gap;
      end else if (!bus.in_valid && gcnt > 0) begin
        gcnt--;
      end
    end
    bus.in_valid = 1'b0;
    chk("res_timeout", (lat < 100), 1);
  endtask

  initial begin
    int lat;
    int rdy_cyc;
    int clr_cyc;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.res_ready = 1'b1;

    // Reset values
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_mac_clr", mac_clr, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_clr", mac_clr, 0);
    chk("idle_busy", bus.busy, 0);

    // Basic job: 15 + 14 + 225 = 254
    run_job(3, '{8'h53, 8'h72, 8'hFF, 8'h00}, 0, lat, rdy_cyc, clr_cyc);
    chk("basic_lat", lat, 6);
    chk("basic_rdy_cycles", rdy_cyc, 3);
    chk("basic_clr_cycles", clr_cyc, 1);
    chk("basic_res_data", bus.res_data, 8'hFE);
    chk("basic_busy", bus.busy, 1);
    tick();
    chk("basic_release_valid", bus.res_valid, 0);
    chk("basic_release_busy", bus.busy, 0);

    // Zero length after C was left at 0xFE
    run_job(0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, lat, rdy_cyc, clr_cyc);
    chk("zero_lat", lat, 3);
    chk("zero_rdy_cycles", rdy_cyc, 0);
    chk("zero_clr_cycles", clr_cyc, 1);
    chk("zero_res_data", bus.res_data, 8'h00);
    tick();

    // Wrap: 450 mod 256 = 194
    run_job(2, '{8'hFF, 8'hFF, 8'h00, 8'h00}, 0, lat, rdy_cyc, clr_cyc);
    chk("wrap_lat", lat, 5);
    chk("wrap_res_data", bus.res_data, 8'hC2);
    tick();

    // Bubbles (2 idle cycles after each beat) and result backpressure
    bus.res_ready = 1'b0;
    run_job(4, '{8'h11, 8'h22, 8'h33, 8'h44}, 2, lat, rdy_cyc, clr_cyc);
    chk("bubble_lat", lat, 13);
    chk("bubble_res_data", bus.res_data, 8'h1E);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.len   = 4'd3;
      tick();
      chk("hold_res_valid", bus.res_valid, 1);
      chk("hold_res_data", bus.res_data, 8'h1E);
    end
    // Start in the release cycle is ignored, then honoured from IDLE
    bus.start = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    chk("release_valid", bus.res_valid, 0);
    chk("release_start_ignored", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    chk("new_job_busy", bus.busy, 1);
    chk("new_job_clr", mac_clr, 1);

    // Reset during FEED after 2 of 3 beats
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    tick();
    chk("feed_in_ready", bus.in_ready, 1);
    tick();
    bus.in_data = 8'h22;
    tick();
    bus.in_valid = 1'b0;
    chk("pre_abort_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_mac_a", mac_a, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_abort_clr", mac_clr, 0);
    chk("post_abort_busy", bus.busy, 0);

    // Rerun after abort: 6*7 = 42
    run_job(1, '{8'h76, 8'h00, 8'h00, 8'h00}, 0, lat, rdy_cyc, clr_cyc);
    chk("rerun_lat", lat, 4);
    chk("rerun_res_data", bus.res_data, 8'h2A);
    tick();
    chk("rerun_release", bus.res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_stream_ctrl.md
Name: mac_stream_ctrl

Overview:
- Operand feeder and result reader for the vedic-multiplier MAC datapath; it is the other end of that datapath's a/b/C interface.
- Accepts a job of LEN packed 4-bit operand pairs over a valid/ready stream.
- Clears the MAC accumulator, issues one pair per accepted beat, waits out the accumulator latency, then captures the accumulator value.
- Presents the captured result on a valid/ready result port. It sits between the host-side input pins and the MAC core.

Parameters:
LEN_W, 4, width of the job-length field; max job length 2^LEN_W-1 pairs.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  job request; sampled only in IDLE
len  input  LEN_W  number of operand pairs in job; latched on accepted start
busy  output  1  high in every state except IDLE
in_valid  input  1  operand beat valid
in_ready  output  1  controller can take a beat; high only in FEED
in_data  input  8  packed pair: [3:0]=a, [7:4]=b
mac_a  output  4  operand a to MAC multiplier, registered
mac_b  output  4  operand b to MAC multiplier, registered
mac_clr  output  1  accumulator clear to MAC reset input, registered, one-cycle pulse
mac_c  input  8  MAC accumulator output C
res_valid  output  1  result available
res_ready  input  1  result consumer accepts
res_data  output  8  captured accumulator value, registered

Behaviour:
- Reset state: IDLE. All outputs 0: busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_data. Internal counters cleared.
- MAC contract: the MAC accumulates C <= C + a*b every clock, unconditionally. When idle, the controller drives mac_a=mac_b=0 so that C holds its value.
- States: IDLE, CLEAR, FEED, DRAIN (2 cycles), HOLD.
- IDLE:
  - start=1 latches len, zeroes the beat counter and goes to CLEAR.
  - start while not IDLE is ignored.
- CLEAR:
  - Lasts exactly 1 cycle. mac_clr=1 for exactly this cycle, registered, glitch-free. mac_a/mac_b=0.
  - Next state: FEED if len!=0, else DRAIN.
- FEED:
  - in_ready=1 (decoded from the state register).
  - On in_valid&in_ready, at the clock edge: mac_a<=in_data[3:0], mac_b<=in_data[7:4], count++.
  - On any cycle without a handshake, mac_a/mac_b<=0 (bubble adds zero).
  - On the edge accepting beat number len, go to DRAIN. in_ready is low from the next cycle. No extra beat is ever accepted.
- DRAIN:
  - Two cycles, mac_a/mac_b=0. This covers one cycle of operand register plus one cycle of accumulator register.
  - On the edge leaving the second DRAIN cycle, res_data<=mac_c, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1; res_data stable.
  - On res_valid&res_ready, at the edge: res_valid<=0, go to IDLE.
  - start asserted in the same cycle is ignored; it is honoured from IDLE on the next cycle.
- Latency with no bubbles: start edge e0 -> res_valid high after edge e0+len+3. For len=0: after edge e0+3.
- Arithmetic: the result is (sum of a*b) mod 256. Accumulator wrap is defined behaviour; no overflow flag.
- Bubbles extend FEED one cycle each; the result is unaffected.
- Reset mid-job, in any state: immediate return to reset values. The job is lost; no partial result is presented. The next job re-clears the accumulator via CLEAR, so stale C never leaks into a result.
- Outputs are never driven combinationally from in_valid, res_ready or start.

Test Plan:
- Reset: assert rst mid-stream, release -> all outputs 0, busy=0, in_ready=0; mac_clr does not pulse until the next start.
- Basic job: start, len=3, beats (a,b)=(3,5),(2,7),(15,15) back-to-back, res_ready=1 -> mac_clr high exactly 1 cycle; in_ready high exactly 3 cycles; res_valid 6 cycles after start edge; res_data=0xFE (15+14+225=254).
- Wrap: len=2, beats (15,15),(15,15) -> res_data=0xC2 (450 mod 256=194).
- Bubbles and backpressure:
  - len=4, beats (1,1),(2,2),(3,3),(4,4) with in_valid low for 2 cycles between each -> res_data=0x1E.
  - res_ready held low 5 cycles -> res_valid and res_data stay constant.
  - A start pulsed during HOLD is ignored; a start after release begins a new job.
- Zero length: len=0 after a prior job that left C=0xFE -> in_ready never high; res_data=0x00; res_valid 3 cycles after start.
- Reset mid-FEED: after 2 of 3 beats, pulse rst -> busy=0, res_valid=0. Then rerun len=1 with (6,7) -> res_data=0x2A, with no residue from the aborted job.
